bin2bcd_seq: RTL

//   Sequential binary-to-BCD converter (shift-add-3 / double-dabble), one bit per clock.

---
 rtl/bin2bcd_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-add-3), one bit per clock.
// Start/busy/done handshake; bcd_out/ovf are updated only on the done edge.
// Optional build macro: BIN2BCD_BLANK_EN enables leading-zero blanking (digit -> 4'hF).
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 7,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int unsigned CW = $clog2(BIN_W + 1);
  localparam int unsigned SW = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [BIN_W-1:0] shift_q, shift_d;
  logic [SW-1:0]   scr_q, scr_d;
  logic            ovf_s_q, ovf_s_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   bcd_q, bcd_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;

  logic [SW-1:0]   adj;
  logic [SW-1:0]   sh_scr;
  logic [BIN_W-1:0] sh_bin;
  logic            sh_out;
  logic            fin_ovf;
  logic [SW-1:0]   fin_bcd;
  logic            lead;

  // One double-dabble step: add 3 to every digit >= 5, then shift {scratch, bin} left.
  always_comb begin
    adj = scr_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
    {sh_out, sh_scr, sh_bin} = {adj, shift_q, 1'b0};
    fin_ovf = ovf_s_q | sh_out;
    fin_bcd = sh_scr;
    lead    = 1'b0;
`ifdef BIN2BCD_BLANK_EN
    // Blank from the top digit down while digits stay zero; digit 0 is never blanked.
    lead = ~fin_ovf;
    for (int unsigned k = 1; k < DIGITS; k++) begin
      if (lead && (sh_scr[4*(DIGITS-k) +: 4] == 4'd0)) begin
        fin_bcd[4*(DIGITS-k) +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
`endif
  end

  // Next-state and register-update logic for the IDLE -> SHIFT -> DONE sequence.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    scr_d   = scr_q;
    ovf_s_d = ovf_s_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d = bin_in;
          scr_d   = '0;
          ovf_s_d = 1'b0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_d = sh_bin;
        scr_d   = sh_scr;
        ovf_s_d = fin_ovf;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(BIN_W - 1)) begin
          bcd_d   = fin_bcd;
          ovf_d   = fin_ovf;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      scr_q   <= '0;
      ovf_s_q <= 1'b0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      scr_q   <= scr_d;
      ovf_s_q <= ovf_s_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;

endmodule
